// File: rtl/vliw_regfile_if.sv
// Lane-side bundle for the shared VLIW integer register file:
// per-lane read/write ports plus write-conflict debug state.
interface vliw_regfile_if #(
  parameter int XLEN   = 32,
  parameter int NLANES = 4,
  parameter int CNTW   = 8
);
  logic [NLANES-1:0]           we3;
  logic [NLANES-1:0][4:0]      a1;
  logic [NLANES-1:0][4:0]      a2;
  logic [NLANES-1:0][4:0]      a3;
  logic [NLANES-1:0][XLEN-1:0] wd3;
  logic [NLANES-1:0][XLEN-1:0] rd1;
  logic [NLANES-1:0][XLEN-1:0] rd2;
  logic                        ClearConflict;
  logic                        WriteConflict;
  logic [CNTW-1:0]             ConflictCount;

  modport master (
    output we3, a1, a2, a3, wd3, ClearConflict,
    input  rd1, rd2, WriteConflict, ConflictCount
  );

  modport slave (
    input  we3, a1, a2, a3, wd3, ClearConflict,
    output rd1, rd2, WriteConflict, ConflictCount
  );
endinterface

// File: rtl/vliw_regfile.sv
// Shared multi-lane integer register file: slot-ordered writes,
// same-cycle Writeback->Decode bypass, write-write conflict tracking.
module vliw_regfile #(
  parameter int XLEN        = 32,
  parameter int NLANES      = 4,
  parameter int E_SUPPORTED = 0,
  parameter int CNTW        = 8
) (
  input logic          clk,
  input logic          reset,
  vliw_regfile_if.slave rf
);
  localparam int NREGS = (E_SUPPORTED != 0) ? 16 : 32;

  logic [XLEN-1:0]             regs [1:NREGS-1];
  logic [NLANES-1:0]           we;
  logic [NLANES-1:0][4:0]      wa;
  logic [NLANES-1:0][XLEN-1:0] wd;
  logic                        conflict;
  logic                        wc_q;
  logic [CNTW-1:0]             cnt_q;

  function automatic logic [4:0] ea(input logic [4:0] a);
    ea = (E_SUPPORTED != 0) ? {1'b0, a[3:0]} : a;
  endfunction

  // Highest lane wins, matching program order inside the bundle.
  function automatic logic [XLEN-1:0] lookup(input logic [4:0] a);
    logic [4:0] aa;
    aa = ea(a);
    lookup = '0;
    if (aa != 5'd0) begin
      for (int r = 1; r < NREGS; r++)
        if (5'(r) == aa) lookup = regs[r];
      for (int k = 0; k < NLANES; k++)
        if (we[k] && wa[k] == aa) lookup = wd[k];
    end
  endfunction

  always_comb begin
    for (int k = 0; k < NLANES; k++) begin
      we[k] = rf.we3[k];
      wa[k] = ea(rf.a3[k]);
      wd[k] = rf.wd3[k];
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int k = 0; k < NLANES; k++)
      for (int j = k + 1; j < NLANES; j++)
        if (we[k] && we[j] && wa[k] != 5'd0 && wa[k] == wa[j])
          conflict = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      rf.rd1[i] = lookup(rf.a1[i]);
      rf.rd2[i] = lookup(rf.a2[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r < NREGS; r++)
        regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++)
        for (int k = 0; k < NLANES; k++)
          if (we[k] && wa[k] == 5'(r))
            regs[r] <= wd[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wc_q  <= 1'b0;
      cnt_q <= '0;
    end else if (rf.ClearConflict) begin
      wc_q  <= 1'b0;
      cnt_q <= '0;
    end else if (conflict) begin
      wc_q <= 1'b1;
      if (cnt_q != {CNTW{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rf.WriteConflict = wc_q;
  assign rf.ConflictCount = cnt_q;
endmodule

// File: tb/tb_vliw_regfile.sv
// Directed bench for vliw_regfile: default 32-reg instance plus
// an RV32E instance sharing clock and reset.
module tb_vliw_regfile;
  logic clk;
  logic reset;
  int   total;
  int   passed;

  vliw_regfile_if #(.XLEN(32), .NLANES(4), .CNTW(8)) rfi ();
  vliw_regfile_if #(.XLEN(32), .NLANES(4), .CNTW(8)) rfe ();

  vliw_regfile #(
    .XLEN(32), .NLANES(4), .E_SUPPORTED(0), .CNTW(8)
  ) u_dut (
    .clk(clk), .reset(reset), .rf(rfi.slave)
  );

  vliw_regfile #(
    .XLEN(32), .NLANES(4), .E_SUPPORTED(1), .CNTW(8)
  ) u_dute (
    .clk(clk), .reset(reset), .rf(rfe.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b0;
    rfi.we3 = '0; rfi.a1 = '0; rfi.a2 = '0; rfi.a3 = '0;
    rfi.wd3 = '0; rfi.ClearConflict = 1'b0;
    rfe.we3 = '0; rfe.a1 = '0; rfe.a2 = '0; rfe.a3 = '0;
    rfe.wd3 = '0; rfe.ClearConflict = 1'b0;

    // reset state
    #12;
    chk("rst_wc", 128'(rfi.WriteConflict), 128'd0);
    chk("rst_cnt", 128'(rfi.ConflictCount), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int a = 1; a < 32; a++) begin
      for (int i = 0; i < 4; i++) begin
        rfi.a1[i] = 5'(a);
        rfi.a2[i] = 5'(a);
      end
      #1;
      chk("rst_rd1", 128'(rfi.rd1), 128'd0);
      chk("rst_rd2", 128'(rfi.rd2), 128'd0);
    end
    rfi.a1 = '0; rfi.a2 = '0;

    // lane0 writes x5, lane2 bypasses it
    @(negedge clk);
    rfi.we3 = 4'b0001;
    rfi.a3[0] = 5'd5;
    rfi.wd3[0] = 32'h1234_5678;
    rfi.a1[2] = 5'd5;
    #1;
    chk("byp_x5", 128'(rfi.rd1[2]), 128'h1234_5678);
    chk("byp_x5_l0", 128'(rfi.rd1[0]), 128'd0);
    @(negedge clk);
    rfi.we3 = '0;
    for (int i = 0; i < 4; i++) rfi.a2[i] = 5'd5;
    #1;
    chk("rd2_x5", 128'(rfi.rd2), {4{32'h1234_5678}});

    // lanes 1 and 3 collide on x7
    @(negedge clk);
    rfi.we3 = 4'b1010;
    rfi.a3[1] = 5'd7; rfi.wd3[1] = 32'h0000_AAAA;
    rfi.a3[3] = 5'd7; rfi.wd3[3] = 32'h0000_BBBB;
    rfi.a1[0] = 5'd7;
    #1;
    chk("byp_x7", 128'(rfi.rd1[0]), 128'h0000_BBBB);
    chk("wc_pre_edge", 128'(rfi.WriteConflict), 128'd0);
    @(negedge clk);
    rfi.we3 = '0;
    for (int i = 0; i < 4; i++) rfi.a1[i] = 5'd7;
    #1;
    chk("x7_stored", 128'(rfi.rd1), {4{32'h0000_BBBB}});
    chk("wc_x7", 128'(rfi.WriteConflict), 128'd1);
    chk("cnt_x7", 128'(rfi.ConflictCount), 128'd1);

    // all lanes write x0
    @(negedge clk);
    rfi.we3 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      rfi.a3[i] = 5'd0;
      rfi.wd3[i] = 32'hFFFF_FFFF;
      rfi.a1[i] = 5'd0;
      rfi.a2[i] = 5'd0;
    end
    #1;
    chk("x0_byp", 128'(rfi.rd1), 128'd0);
    @(negedge clk);
    rfi.we3 = '0;
    #1;
    chk("x0_rd", 128'(rfi.rd2), 128'd0);
    chk("x0_cnt", 128'(rfi.ConflictCount), 128'd1);

    // 300 conflict cycles on x9 saturate the counter
    @(negedge clk);
    rfi.we3 = 4'b0011;
    rfi.a3[0] = 5'd9; rfi.wd3[0] = 32'h0000_0009;
    rfi.a3[1] = 5'd9; rfi.wd3[1] = 32'h0000_0019;
    rfi.a1[3] = 5'd9;
    repeat (10) @(negedge clk);
    #1;
    chk("cnt_mid", 128'(rfi.ConflictCount), 128'd11);
    repeat (290) @(negedge clk);
    #1;
    chk("cnt_sat", 128'(rfi.ConflictCount), 128'd255);
    chk("wc_sat", 128'(rfi.WriteConflict), 128'd1);
    rfi.ClearConflict = 1'b1;
    @(negedge clk);
    rfi.ClearConflict = 1'b0;
    rfi.we3 = '0;
    #1;
    chk("clr_wc", 128'(rfi.WriteConflict), 128'd0);
    chk("clr_cnt", 128'(rfi.ConflictCount), 128'd0);
    chk("x9_val", 128'(rfi.rd1[3]), 128'h0000_0019);

    // RV32E: address bit 4 ignored
    @(negedge clk);
    rfe.we3 = 4'b0001;
    rfe.a3[0] = 5'b10011;
    rfe.wd3[0] = 32'h0000_0055;
    @(negedge clk);
    rfe.we3 = '0;
    rfe.a1[1] = 5'b00011;
    rfe.a2[2] = 5'b10011;
    #1;
    chk("e_rd1", 128'(rfe.rd1[1]), 128'h55);
    chk("e_rd2", 128'(rfe.rd2[2]), 128'h55);
    rfe.we3 = 4'b0100;
    rfe.a3[2] = 5'b10110;
    rfe.wd3[2] = 32'h0000_0066;
    rfe.a1[3] = 5'b00110;
    #1;
    chk("e_byp", 128'(rfe.rd1[3]), 128'h66);
    @(negedge clk);
    rfe.we3 = 4'b0011;
    rfe.a3[0] = 5'b00100; rfe.wd3[0] = 32'h0000_0001;
    rfe.a3[1] = 5'b10100; rfe.wd3[1] = 32'h0000_0002;
    @(negedge clk);
    rfe.we3 = '0;
    rfe.a1[0] = 5'd4;
    #1;
    chk("e_wc", 128'(rfe.WriteConflict), 128'd1);
    chk("e_cnt", 128'(rfe.ConflictCount), 128'd1);
    chk("e_x4", 128'(rfe.rd1[0]), 128'h2);

    // async reset mid-cycle clears contents and flags at once
    #2;
    reset = 1'b0;
    #1;
    chk("e_rst_rd1", 128'(rfe.rd1), 128'd0);
    chk("e_rst_rd2", 128'(rfe.rd2), 128'd0);
    chk("e_rst_wc", 128'(rfe.WriteConflict), 128'd0);
    chk("e_rst_cnt", 128'(rfe.ConflictCount), 128'd0);
    chk("rst_x9", 128'(rfi.rd1[3]), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
